// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM/WB stage (master) and data memory (slave).
interface mem_wb_stage_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [3:0]        be;
  logic              ack;
  logic [WORD_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access + writeback pipeline stage: latches the EX result, runs one load/store on the
// req/ack data bus while stalling the front end, then formats load data for the register file.
module mem_wb_stage #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int REG_IDX_W  = 5,
  parameter int MEM_OP_W   = 4,
  parameter int DEST_SRC_W = 2
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  clr,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [WORD_W-1:0]     i_alu_eval,
  input  logic [WORD_W-1:0]     i_store_data,
  input  logic [MEM_OP_W-1:0]   i_mem_op,
  input  logic [DEST_SRC_W-1:0] i_dest_src,
  input  logic [REG_IDX_W-1:0]  i_dest_reg,
  mem_wb_stage_if.master        dmem,
  output logic                  o_stall,
  output logic                  o_misaligned,
  output logic [ADDR_W-1:0]     o_pc,
  output logic                  o_wb_dest_en,
  output logic [REG_IDX_W-1:0]  o_wb_dest_reg,
  output logic [WORD_W-1:0]     o_wb_dest_data,
  output logic [REG_IDX_W-1:0]  o_me_dest_reg,
  output logic [DEST_SRC_W-1:0] o_me_dest_src,
  output logic [WORD_W-1:0]     o_me_mem_read
);

  localparam logic [MEM_OP_W-1:0] OP_NONE = MEM_OP_W'(0);
  localparam logic [MEM_OP_W-1:0] OP_LB   = MEM_OP_W'(1);
  localparam logic [MEM_OP_W-1:0] OP_LH   = MEM_OP_W'(2);
  localparam logic [MEM_OP_W-1:0] OP_LW   = MEM_OP_W'(3);
  localparam logic [MEM_OP_W-1:0] OP_LBU  = MEM_OP_W'(4);
  localparam logic [MEM_OP_W-1:0] OP_LHU  = MEM_OP_W'(5);
  localparam logic [MEM_OP_W-1:0] OP_SB   = MEM_OP_W'(8);
  localparam logic [MEM_OP_W-1:0] OP_SH   = MEM_OP_W'(9);
  localparam logic [MEM_OP_W-1:0] OP_SW   = MEM_OP_W'(10);

  localparam logic [DEST_SRC_W-1:0] SRC_NONE = DEST_SRC_W'(0);
  localparam logic [DEST_SRC_W-1:0] SRC_ALU  = DEST_SRC_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WORD_W-1:0]     sdata_q, sdata_d;
  logic [MEM_OP_W-1:0]   op_q, op_d;
  logic [DEST_SRC_W-1:0] dest_src_q, dest_src_d;
  logic [REG_IDX_W-1:0]  dest_reg_q, dest_reg_d;
  logic [WORD_W-1:0]     load_q, load_d;

  function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [MEM_OP_W-1:0] op, input logic [1:0] lane);
    logic half_op;
    logic word_op;
    half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    word_op = (op == OP_LW) || (op == OP_SW);
    return (half_op && lane[0]) || (word_op && (lane != 2'b00));
  endfunction

  // Lane selection for loads; the word is assumed to be 32 bits wide.
  function automatic logic [WORD_W-1:0] format_load(input logic [MEM_OP_W-1:0] op,
                                                    input logic [1:0]          lane,
                                                    input logic [WORD_W-1:0]   word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [WORD_W-1:0] res;
    case (lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   res = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  res = {24'b0, byte_v};
      OP_LH:   res = {{16{half_v[15]}}, half_v};
      OP_LHU:  res = {16'b0, half_v};
      default: res = word;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    op_d       = op_q;
    dest_src_d = dest_src_q;
    dest_reg_d = dest_reg_q;
    load_d     = load_q;

    if (state_q == REQ) begin
      if (dmem.ack) begin
        state_d = RESP;
        load_d  = format_load(op_q, addr_q[1:0], dmem.rdata);
      end
    end else if (clr) begin
      state_d    = IDLE;
      pc_d       = '0;
      addr_d     = '0;
      sdata_d    = '0;
      op_d       = OP_NONE;
      dest_src_d = SRC_NONE;
      dest_reg_d = '0;
    end else begin
      pc_d       = i_pc;
      addr_d     = ADDR_W'(i_alu_eval);
      sdata_d    = i_store_data;
      op_d       = i_mem_op;
      dest_src_d = i_dest_src;
      dest_reg_d = i_dest_reg;
      if ((is_load(i_mem_op) || is_store(i_mem_op)) &&
          !is_misaligned(i_mem_op, i_alu_eval[1:0])) begin
        state_d = REQ;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      addr_q     <= '0;
      sdata_q    <= '0;
      op_q       <= OP_NONE;
      dest_src_q <= SRC_NONE;
      dest_reg_q <= '0;
      load_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      op_q       <= op_d;
      dest_src_q <= dest_src_d;
      dest_reg_q <= dest_reg_d;
      load_q     <= load_d;
    end
  end

  // Bus outputs are forced to zero outside REQ so the memory never sees stale requests.
  always_comb begin
    dmem.req   = 1'b0;
    dmem.we    = 1'b0;
    dmem.addr  = '0;
    dmem.wdata = '0;
    dmem.be    = 4'b0000;
    if (state_q == REQ) begin
      dmem.req  = 1'b1;
      dmem.we   = is_store(op_q);
      dmem.addr = {addr_q[ADDR_W-1:2], 2'b00};
      case (op_q)
        OP_SB: begin
          dmem.wdata = {4{sdata_q[7:0]}};
          dmem.be    = 4'b0001 << addr_q[1:0];
        end
        OP_SH: begin
          dmem.wdata = {2{sdata_q[15:0]}};
          dmem.be    = 4'b0011 << addr_q[1:0];
        end
        OP_SW: begin
          dmem.wdata = sdata_q;
          dmem.be    = 4'b1111;
        end
        default: begin
          dmem.wdata = '0;
          dmem.be    = 4'b1111;
        end
      endcase
    end
  end

  assign o_stall      = (state_q == REQ);
  assign o_misaligned = is_misaligned(op_q, addr_q[1:0]);
  assign o_pc         = pc_q;

  assign o_wb_dest_en   = (dest_src_q != SRC_NONE) && (dest_reg_q != '0) && (state_q != REQ) &&
                          !o_misaligned && !is_store(op_q) &&
                          ((dest_src_q == SRC_ALU) || (state_q == RESP));
  assign o_wb_dest_reg  = dest_reg_q;
  assign o_wb_dest_data = (dest_src_q == SRC_ALU) ? WORD_W'(addr_q) : load_q;

  assign o_me_dest_reg  = dest_reg_q;
  assign o_me_dest_src  = dest_src_q;
  assign o_me_mem_read  = load_q;

endmodule
